// File: rtl/cr_cg_rbus_cfg_node.sv
// Ring-bus configuration node: claims an address window, serves R/W config registers plus a revision register.
// Optional shadow/commit register staging is enabled by defining CR_CG_RBUS_CFG_NODE_SHADOW_EN.
module cr_cg_rbus_cfg_node #(
    parameter int                         ADDR_W    = 20,
    parameter int                         DATA_W    = 32,
    parameter int                         NUM_REGS  = 4,
    parameter logic [7:0]                 REVID     = 8'h00,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] WR_MASK   = '1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            cfg_start_addr,
    input  logic [ADDR_W-1:0]            cfg_end_addr,
    input  logic [ADDR_W-1:0]            rbus_addr_i,
    input  logic [DATA_W-1:0]            rbus_wr_data_i,
    input  logic [DATA_W-1:0]            rbus_rd_data_i,
    input  logic                         rbus_wr_strb_i,
    input  logic                         rbus_rd_strb_i,
    input  logic                         rbus_ack_i,
    input  logic                         rbus_err_ack_i,
    output logic [ADDR_W-1:0]            rbus_addr_o,
    output logic [DATA_W-1:0]            rbus_wr_data_o,
    output logic [DATA_W-1:0]            rbus_rd_data_o,
    output logic                         rbus_wr_strb_o,
    output logic                         rbus_rd_strb_o,
    output logic                         rbus_ack_o,
    output logic                         rbus_err_ack_o,
    input  logic                         commit_i,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_regs_o,
    output logic                         wr_stb_o,
    output logic                         rd_stb_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;

    state_t                       state;
    logic [NUM_REGS*DATA_W-1:0]   live_q;
    logic [NUM_REGS*DATA_W-1:0]   src_q;
    logic [IDX_W-1:0]             idx_p1;
    logic                         rev_p1;
    logic [DATA_W-1:0]            wdata_p1;
    logic                         wr_vld_p1;
    logic                         rd_vld_p1;
    logic                         err_p1;
    logic                         buf_vld;
    logic                         buf_ack;
    logic                         buf_err;
    logic [DATA_W-1:0]            buf_data;

    logic                         in_win;
    logic                         hit;
    logic [ADDR_W-1:0]            off;
    logic                         is_reg;
    logic                         is_rev;
    logic                         err;
    logic [DATA_W-1:0]            cur_word;
    logic [DATA_W-1:0]            mask_word;
    logic [DATA_W-1:0]            new_word;
    logic [DATA_W-1:0]            rd_word;

    // An inverted window (start > end) can never satisfy both bounds, so it passes everything.
    assign in_win = (rbus_addr_i >= cfg_start_addr) && (rbus_addr_i <= cfg_end_addr);
    assign hit    = (state == IDLE) && (rbus_wr_strb_i || rbus_rd_strb_i) && in_win;
    assign off    = rbus_addr_i - cfg_start_addr;
    assign is_reg = off < ADDR_W'(NUM_REGS);
    assign is_rev = off == ADDR_W'(NUM_REGS);
    assign err    = (rbus_wr_strb_i && rbus_rd_strb_i) || (!is_reg && !is_rev)
                    || (rbus_wr_strb_i && is_rev);

    assign cur_word  = src_q[idx_p1*DATA_W +: DATA_W];
    assign mask_word = WR_MASK[idx_p1*DATA_W +: DATA_W];
    assign new_word  = (cur_word & ~mask_word) | (wdata_p1 & mask_word);
    assign rd_word   = rev_p1 ? DATA_W'(REVID) : cur_word;
    assign cfg_regs_o = live_q;

`ifdef CR_CG_RBUS_CFG_NODE_SHADOW_EN
    logic [NUM_REGS*DATA_W-1:0] shadow_q;
    assign src_q = shadow_q;

    // Commit copies the shadow as it stood before any write landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RESET_VAL;
            live_q   <= RESET_VAL;
        end else begin
            if (commit_i) live_q <= shadow_q;
            if (state == DECODE && wr_vld_p1) shadow_q[idx_p1*DATA_W +: DATA_W] <= new_word;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit_i;
    assign src_q = live_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= RESET_VAL;
        end else if (state == DECODE && wr_vld_p1) begin
            live_q[idx_p1*DATA_W +: DATA_W] <= new_word;
        end
    end
`endif

    // Stage p1: captured request data, no reset needed.
    always_ff @(posedge clk) begin
        if (hit) begin
            idx_p1   <= off[IDX_W-1:0];
            rev_p1   <= is_rev;
            wdata_p1 <= rbus_wr_data_i;
        end
        if (state == DECODE) buf_data <= rbus_rd_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rbus_addr_o    <= '0;
            rbus_wr_data_o <= '0;
            rbus_rd_data_o <= '0;
            rbus_wr_strb_o <= 1'b0;
            rbus_rd_strb_o <= 1'b0;
            rbus_ack_o     <= 1'b0;
            rbus_err_ack_o <= 1'b0;
            wr_stb_o       <= 1'b0;
            rd_stb_o       <= 1'b0;
            wr_vld_p1      <= 1'b0;
            rd_vld_p1      <= 1'b0;
            err_p1         <= 1'b0;
            buf_vld        <= 1'b0;
            buf_ack        <= 1'b0;
            buf_err        <= 1'b0;
        end else begin
            wr_stb_o <= 1'b0;
            rd_stb_o <= 1'b0;

            // Request side: a local hit is squashed with address/data held.
            if (hit) begin
                rbus_wr_strb_o <= 1'b0;
                rbus_rd_strb_o <= 1'b0;
            end else begin
                rbus_addr_o    <= rbus_addr_i;
                rbus_wr_data_o <= rbus_wr_data_i;
                rbus_wr_strb_o <= rbus_wr_strb_i;
                rbus_rd_strb_o <= rbus_rd_strb_i;
            end

            case (state)
                IDLE: begin
                    if (hit) begin
                        state     <= DECODE;
                        wr_vld_p1 <= rbus_wr_strb_i && !err;
                        rd_vld_p1 <= rbus_rd_strb_i && !err;
                        err_p1    <= err;
                        wr_stb_o  <= rbus_wr_strb_i && !err;
                        rd_stb_o  <= rbus_rd_strb_i && !err;
                    end
                end
                DECODE:  state <= RESP;
                default: state <= IDLE;
            endcase

            // Response side: local response wins; a colliding upstream response waits one cycle.
            if (state == DECODE) begin
                rbus_ack_o     <= !err_p1;
                rbus_err_ack_o <= err_p1;
                rbus_rd_data_o <= rd_vld_p1 ? rd_word : '0;
                if (rbus_ack_i || rbus_err_ack_i) begin
                    buf_vld <= 1'b1;
                    buf_ack <= rbus_ack_i;
                    buf_err <= rbus_err_ack_i;
                end
            end else if (buf_vld) begin
                rbus_ack_o     <= buf_ack;
                rbus_err_ack_o <= buf_err;
                rbus_rd_data_o <= buf_data;
                buf_vld        <= 1'b0;
            end else begin
                rbus_ack_o     <= rbus_ack_i;
                rbus_err_ack_o <= rbus_err_ack_i;
                rbus_rd_data_o <= rbus_rd_data_i;
            end
        end
    end

endmodule
